// File: rtl/shift_frame_sequencer.sv
// Drives a parallel word bit-serially into a DEPTH-stage shift register and reassembles it from the far end.
// Result appears WIDTH+DEPTH cycles after accept; DONE holds until out_ready, and in_ready stays low for the whole frame.
module shift_frame_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_e,
  input  logic             ser_a,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_match,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int CW = $clog2(DEPTH + WIDTH + 1);
  localparam logic [CW-1:0] LAST_TX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] SAMP_LO = CW'(DEPTH);
  localparam logic [CW-1:0] SAMP_HI = CW'(DEPTH + WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             ser_e_q, ser_e_d;
  logic             match_q, match_d;
  logic [7:0]       frame_q, frame_d;
  logic [7:0]       err_q, err_d;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Reassembly mirrors transmit order so a clean loop returns the word unchanged.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return MSB_FIRST ? ((w << 1) | WIDTH'(b)) : ((w >> 1) | (WIDTH'(b) << (WIDTH - 1)));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ser_e_d = 1'b0;
    match_d = match_q;
    frame_d = frame_q;
    err_d   = err_q;

    if ((state_q == S_SHIFT || state_q == S_FLUSH) && cnt_q >= SAMP_LO && cnt_q <= SAMP_HI) begin
      rx_d = shift_in(rx_q, ser_a);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tx_d    = in_data;
          sh_d    = shift_out(in_data);
          cnt_d   = '0;
          rx_d    = '0;
          match_d = 1'b0;
          ser_e_d = first_bit(in_data);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_TX) begin
          state_d = S_FLUSH;
        end else begin
          ser_e_d = first_bit(sh_q);
          sh_d    = shift_out(sh_q);
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == SAMP_HI) begin
          match_d = (rx_d == tx_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          frame_d = frame_q + 8'd1;
          if (!match_q && err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ser_e_q <= 1'b0;
      match_q <= 1'b0;
      frame_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ser_e_q <= ser_e_d;
      match_q <= match_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // in_ready is gated by clear so it drops the instant reset is asserted.
  assign in_ready  = clear && (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_FLUSH);
  assign out_valid = (state_q == S_DONE);
  assign ser_e     = ser_e_q;
  assign out_data  = rx_q;
  assign out_match = match_q;
  assign frame_cnt = frame_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Bench: two sequencers (MSB-first and LSB-first) each looped through a 4-stage shift register model.
module tb_shift_frame_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       fault = 1'b0;

  logic       in_ready_m, ser_e_m, ser_a_m, busy_m, out_valid_m, out_match_m;
  logic [7:0] out_data_m, frame_cnt_m, err_cnt_m;
  logic       in_ready_l, ser_e_l, ser_a_l, busy_l, out_valid_l, out_match_l;
  logic [7:0] out_data_l, frame_cnt_l, err_cnt_l;
  logic [3:0] sr_m, sr_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sr_m <= 4'h0;
      sr_l <= 4'h0;
    end else begin
      sr_m <= {sr_m[2:0], ser_e_m};
      sr_l <= {sr_l[2:0], ser_e_l};
    end
  end
  assign ser_a_m = sr_m[3] | fault;
  assign ser_a_l = sr_l[3];

  shift_frame_sequencer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .ser_e(ser_e_m), .ser_a(ser_a_m), .busy(busy_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_data(out_data_m), .out_match(out_match_m), .frame_cnt(frame_cnt_m), .err_cnt(err_cnt_m)
  );

  shift_frame_sequencer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .ser_e(ser_e_l), .ser_a(ser_a_l), .busy(busy_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .out_match(out_match_l), .frame_cnt(frame_cnt_l), .err_cnt(err_cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    in_valid = 1'b0;
    fault = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
  endtask

  // Accepts one word, collects the serial stream, returns just after out_valid is seen.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [7:0] exp_m,
                           input logic exp_match, input bit inject);
    logic [7:0] bits_m, bits_l;
    int w, lat;
    w = 0;
    while (!in_ready_m && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready_m}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, busy_m}, 32'd1);
    bits_m = {7'd0, ser_e_m};
    bits_l = 8'd0;
    bits_l[0] = ser_e_l;
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      tick();
      if (k < 8) begin
        bits_m = {bits_m[6:0], ser_e_m};
        bits_l[k] = ser_e_l;
      end
      if (k == 8) check({tag, "_ser_idle"}, {30'd0, ser_e_m, ser_e_l}, 32'd0);
      if (inject && k == 4) fault = 1'b1;
      if (k == 5) fault = 1'b0;
      if (out_valid_m) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, 32'd12);
    check({tag, "_ser_msb"}, {24'd0, bits_m}, {24'd0, data});
    check({tag, "_ser_lsb"}, {24'd0, bits_l}, {24'd0, data});
    check({tag, "_data"}, {24'd0, out_data_m}, {24'd0, exp_m});
    check({tag, "_match"}, {31'd0, out_match_m}, {31'd0, exp_match});
    check({tag, "_data_lsb"}, {23'd0, out_valid_l, out_data_l}, {23'd1, data});
    check({tag, "_match_lsb"}, {31'd0, out_match_l}, 32'd1);
  endtask

  initial begin
    logic [7:0] od[2];
    logic       om[2];
    int outs, accepts, acc1, acc2, bad;
    logic prev_acc;

    // Reset state
    do_reset();
    check("rst_ready", {31'd0, in_ready_m}, 32'd1);
    check("rst_flags", {28'd0, ser_e_m, busy_m, out_valid_m, out_match_m}, 32'd0);
    check("rst_data", {24'd0, out_data_m}, 32'd0);
    check("rst_cnts", {16'd0, frame_cnt_m, err_cnt_m}, 32'd0);

    // Single frame
    out_ready = 1'b1;
    run_frame("single", 8'hB2, 8'hB2, 1'b1, 1'b0);
    tick();
    check("single_fcnt", {24'd0, frame_cnt_m}, 32'd1);
    check("single_ecnt", {24'd0, err_cnt_m}, 32'd0);
    check("single_ready", {31'd0, in_ready_m}, 32'd1);

    // Back-to-back with in_valid held
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    prev_acc = in_ready_m && in_valid;
    outs = 0; accepts = 0; acc1 = -1; acc2 = -1;
    for (int k = 1; k < 60; k++) begin
      @(posedge clock);
      #1;
      if (prev_acc) begin
        accepts++;
        if (accepts == 1) begin
          acc1 = k;
          in_data = 8'hFF;
        end else begin
          acc2 = k;
          in_valid = 1'b0;
        end
      end
      if (out_valid_m && outs < 2) begin
        od[outs] = out_data_m;
        om[outs] = out_match_m;
        outs++;
      end
      prev_acc = in_ready_m && in_valid;
      if (outs == 2) begin
        tick();
        break;
      end
    end
    check("b2b_outs", outs, 32'd2);
    check("b2b_gap", acc2 - acc1, 32'd14);
    if (outs == 2) begin
      check("b2b_d0", {23'd0, om[0], od[0]}, {23'd1, 8'h5A});
      check("b2b_d1", {23'd0, om[1], od[1]}, {23'd1, 8'hFF});
    end
    check("b2b_fcnt", {24'd0, frame_cnt_m}, 32'd2);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    run_frame("bp", 8'hA7, 8'hA7, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!out_valid_m || out_data_m != 8'hA7 || !out_match_m || in_ready_m) bad++;
    end
    check("bp_hold", bad, 32'd0);
    check("bp_fcnt_hold", {24'd0, frame_cnt_m}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, out_valid_m, in_ready_m}, 32'd1);
    check("bp_fcnt", {24'd0, frame_cnt_m}, 32'd1);

    // Fault injection on the first sample edge
    do_reset();
    run_frame("fault", 8'h0F, 8'h8F, 1'b0, 1'b1);
    tick();
    check("fault_ecnt", {24'd0, err_cnt_m}, 32'd1);
    check("fault_fcnt", {24'd0, frame_cnt_m}, 32'd1);
    check("fault_ecnt_lsb", {24'd0, err_cnt_l}, 32'd0);

    // Reset mid-frame
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("midrst_pre_busy", {31'd0, busy_m}, 32'd1);
    clear = 1'b0;
    #1;
    check("midrst_flags", {28'd0, ser_e_m, busy_m, out_valid_m, out_match_m}, 32'd0);
    check("midrst_data", {24'd0, out_data_m}, 32'd0);
    check("midrst_cnts", {16'd0, frame_cnt_m, err_cnt_m}, 32'd0);
    tick();
    tick();
    clear = 1'b1;
    tick();
    run_frame("midrst", 8'h3C, 8'h3C, 1'b1, 1'b0);
    tick();
    check("midrst_fcnt", {24'd0, frame_cnt_m}, 32'd1);

    // LSB-first build with a single set bit
    do_reset();
    run_frame("lsb", 8'h01, 8'h01, 1'b1, 1'b0);
    tick();
    check("lsb_fcnt", {24'd0, frame_cnt_l}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
